// File: rtl/mmio_timer_bridge.sv
// mmio_timer_bridge: memory-mapped I/O bridge for the multicycle MIPS core.
// Decodes a 256-byte window at BASE. Inside the window it exposes an LED
// register, a free-running cycle counter and, when MMIO_TIMER_EN is defined,
// a down-counting interval timer with an expiry flag driving irq.
// All other accesses pass straight through to the unified memory.
// Optional feature macro: MMIO_TIMER_EN (undefined = no timer hardware).
module mmio_timer_bridge #(
  parameter logic [31:0] BASE = 32'hFFFF_FF00,
  parameter int          LEDW = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [31:0]     adr,
  input  logic [31:0]     writedata,
  input  logic            memwrite,
  input  logic [31:0]     memrd,
  output logic            memwe,
  output logic [31:0]     readdata,
  output logic [LEDW-1:0] led,
  output logic            irq
);

  localparam logic [2:0] OFF_LED    = 3'd0;
  localparam logic [2:0] OFF_CYCLE  = 3'd1;
  localparam logic [2:0] OFF_TLOAD  = 3'd2;
  localparam logic [2:0] OFF_TCTRL  = 3'd3;
  localparam logic [2:0] OFF_TCOUNT = 3'd4;

  logic        hit;
  logic        reg_hit;
  logic [2:0]  off;
  logic        reg_wr;
  logic [31:0] reg_rdata;

  logic [LEDW-1:0] led_q, led_d;
  logic [31:0]     cycle_q, cycle_d;

  // Byte-lane bits are ignored; writedata bits above LEDW are unused without the timer.
  logic unused_bits;
  assign unused_bits = ^{adr[1:0], writedata};

  // Window decode: any in-window address is swallowed, but only adr[7:5]==0 selects a register.
  assign hit     = (adr[31:8] == BASE[31:8]);
  assign reg_hit = hit && (adr[7:5] == 3'b000);
  assign off     = adr[4:2];
  assign reg_wr  = memwrite && reg_hit;

  // In-window stores never reach memory.
  assign memwe = memwrite & ~hit;

  // LED register and cycle counter next state.
  always_comb begin
    led_d   = led_q;
    cycle_d = cycle_q + 32'd1;
    if (reg_wr && (off == OFF_LED)) begin
      led_d = writedata[LEDW-1:0];
    end
  end

  // LED register and free-running cycle counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      led_q   <= '0;
      cycle_q <= '0;
    end else begin
      led_q   <= led_d;
      cycle_q <= cycle_d;
    end
  end

  assign led = led_q;

`ifdef MMIO_TIMER_EN
  logic [31:0] tload_q, tload_d;
  logic [31:0] tcount_q, tcount_d;
  logic        en_q, en_d;
  logic        auto_q, auto_d;
  logic        exp_q, exp_d;
  logic        expire;

  // Timer step first, then bus writes override: a TLOAD write beats the
  // decrement/reload, a TCTRL write sets EN/AUTO, and an expiry beats W1C.
  always_comb begin
    tload_d  = tload_q;
    tcount_d = tcount_q;
    en_d     = en_q;
    auto_d   = auto_q;
    exp_d    = exp_q;
    expire   = 1'b0;

    if (en_q) begin
      if (tcount_q != 32'd0) begin
        tcount_d = tcount_q - 32'd1;
      end else begin
        expire = 1'b1;
        if (auto_q) begin
          tcount_d = tload_q;
        end else begin
          en_d = 1'b0;
        end
      end
    end

    if (reg_wr && (off == OFF_TLOAD)) begin
      tload_d  = writedata;
      tcount_d = writedata;
    end

    if (reg_wr && (off == OFF_TCTRL)) begin
      en_d   = writedata[0];
      auto_d = writedata[1];
      if (writedata[2]) begin
        exp_d = 1'b0;
      end
    end

    if (expire) begin
      exp_d = 1'b1;
    end
  end

  // Timer state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      tload_q  <= '0;
      tcount_q <= '0;
      en_q     <= 1'b0;
      auto_q   <= 1'b0;
      exp_q    <= 1'b0;
    end else begin
      tload_q  <= tload_d;
      tcount_q <= tcount_d;
      en_q     <= en_d;
      auto_q   <= auto_d;
      exp_q    <= exp_d;
    end
  end

  assign irq = exp_q;
`else
  assign irq = 1'b0;
`endif

  // Register read mux; unmapped offsets and the absent timer read as zero.
  always_comb begin
    reg_rdata = 32'd0;
    if (reg_hit) begin
      case (off)
        OFF_LED:    reg_rdata = 32'(led_q);
        OFF_CYCLE:  reg_rdata = cycle_q;
`ifdef MMIO_TIMER_EN
        OFF_TLOAD:  reg_rdata = tload_q;
        OFF_TCTRL:  reg_rdata = {29'd0, exp_q, auto_q, en_q};
        OFF_TCOUNT: reg_rdata = tcount_q;
`endif
        default:    reg_rdata = 32'd0;
      endcase
    end
  end

  assign readdata = hit ? reg_rdata : memrd;

endmodule

// File: tb/tb_mmio_timer_bridge.sv
// tb_mmio_timer_bridge: directed test-plan sequences followed by random
// lw/sw traffic, every cycle checked against a behavioural model of the
// register map and timer rules.
module tb_mmio_timer_bridge;

  localparam logic [31:0] BASE     = 32'hFFFF_FF00;
  localparam int          LEDW     = 8;
  localparam logic [31:0] LED_MASK = 32'h0000_00FF;
`ifdef MMIO_TIMER_EN
  localparam bit TIMER = 1'b1;
`else
  localparam bit TIMER = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset;
  logic [31:0]     adr;
  logic [31:0]     writedata;
  logic            memwrite;
  logic [31:0]     memrd;
  logic            memwe;
  logic [31:0]     readdata;
  logic [LEDW-1:0] led;
  logic            irq;

  always #5 clk = ~clk;

  mmio_timer_bridge #(.BASE(BASE), .LEDW(LEDW)) dut (
    .clk       (clk),
    .reset     (reset),
    .adr       (adr),
    .writedata (writedata),
    .memwrite  (memwrite),
    .memrd     (memrd),
    .memwe     (memwe),
    .readdata  (readdata),
    .led       (led),
    .irq       (irq)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [31:0] m_led    = 32'd0;
  logic [31:0] m_cycle  = 32'd0;
  logic [31:0] m_tload  = 32'd0;
  logic [31:0] m_tcount = 32'd0;
  logic        m_en     = 1'b0;
  logic        m_auto   = 1'b0;
  logic        m_exp    = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s got=%08h want=%08h", tag, got, want);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] a, input logic [31:0] mem);
    if (a[31:8] != BASE[31:8]) return mem;
    if (a[7:5] != 3'd0) return 32'd0;
    case (a[4:2])
      3'd0: return m_led;
      3'd1: return m_cycle;
      3'd2: return TIMER ? m_tload : 32'd0;
      3'd3: return TIMER ? {29'd0, m_exp, m_auto, m_en} : 32'd0;
      3'd4: return TIMER ? m_tcount : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  // Apply one rising edge to the model.
  task automatic model_clock(input logic rst, input logic [31:0] a, input logic [31:0] wd, input logic we);
    logic        sel;
    logic [31:0] nc;
    logic        ne, na, fire, clr;
    if (rst) begin
      m_led = 0; m_cycle = 0; m_tload = 0; m_tcount = 0;
      m_en = 0; m_auto = 0; m_exp = 0;
      return;
    end
    sel = we && (a[31:8] == BASE[31:8]) && (a[7:5] == 3'd0);
    m_cycle = m_cycle + 32'd1;
    if (sel && a[4:2] == 3'd0) m_led = wd & LED_MASK;
    if (TIMER) begin
      nc = m_tcount; ne = m_en; na = m_auto; fire = 1'b0; clr = 1'b0;
      if (m_en) begin
        if (m_tcount != 0) nc = m_tcount - 1;
        else begin
          fire = 1'b1;
          if (m_auto) nc = m_tload;
          else ne = 1'b0;
        end
      end
      if (sel && a[4:2] == 3'd2) begin
        m_tload = wd;
        nc = wd;
      end
      if (sel && a[4:2] == 3'd3) begin
        ne = wd[0]; na = wd[1]; clr = wd[2];
      end
      m_tcount = nc; m_en = ne; m_auto = na;
      if (fire) m_exp = 1'b1;
      else if (clr) m_exp = 1'b0;
    end
  endtask

  // One bus cycle: drive, check combinational outputs mid-cycle, clock, update model.
  task automatic step(input logic rst, input logic [31:0] a, input logic [31:0] wd,
                      input logic we, input bit chk, input string tag);
    logic [31:0] want_rd;
    reset = rst; adr = a; writedata = wd; memwrite = we; memrd = $urandom;
    #2;
    if (chk) begin
      want_rd = model_read(a, memrd);
      check_eq({tag, ":rd"},  readdata,        want_rd);
      check_eq({tag, ":we"},  {31'd0, memwe},  {31'd0, we & (a[31:8] != BASE[31:8])});
      check_eq({tag, ":led"}, 32'(led),        m_led);
      check_eq({tag, ":irq"}, {31'd0, irq},    {31'd0, m_exp});
    end
    $display("%-6s rst=%0d adr=%08h wd=%08h we=%0d rd=%08h irq=%0d", tag, rst, a, wd, we, readdata, irq);
    @(posedge clk);
    model_clock(rst, a, wd, we);
    #1;
  endtask

  task automatic rd(input logic [31:0] a, input string tag);
    step(1'b0, a, $urandom, 1'b0, 1'b1, tag);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] wd, input string tag);
    step(1'b0, a, wd, 1'b1, 1'b1, tag);
  endtask

  initial begin
    logic [31:0] a, wd;
    logic        we, rst;
    int          r;

    // Reset two cycles; the first edge initialises the DUT so it is not checked.
    step(1'b1, 32'd0, 32'd0, 1'b0, 1'b0, "rst0");
    step(1'b1, 32'd0, 32'd0, 1'b0, 1'b1, "rst1");

    // Idle, reading CYCLE: cycle k after reset returns k.
    for (int i = 0; i < 10; i++) rd(BASE + 32'h4, "cyc");

    // LED store and readback; store into memory.
    wr(BASE, 32'h0000_00A5, "ledw");
    rd(BASE, "ledr");
    wr(32'h0000_0040, 32'h0000_1234, "memw");
    rd(32'h0000_0040, "memr");
    rd(BASE, "ledr2");

    // Auto-reload timer, period 4.
    wr(BASE + 32'h8, 32'd3, "tld");
    wr(BASE + 32'hC, 32'h3, "tctl");
    for (int i = 0; i < 6; i++) rd(BASE + 32'h10, "tcnt");
    wr(BASE + 32'hC, 32'h7, "w1c");
    for (int i = 0; i < 6; i++) rd(BASE + 32'hC, "tsts");

    // One-shot timer runs to completion.
    wr(BASE + 32'hC, 32'h4, "stop");
    wr(BASE + 32'h8, 32'd2, "tld2");
    wr(BASE + 32'hC, 32'h1, "one");
    for (int i = 0; i < 5; i++) rd(BASE + 32'hC, "osts");
    rd(BASE + 32'h10, "ocnt");

    // Re-arm one-shot and W1C exactly on the expiry edge.
    wr(BASE + 32'hC, 32'h4, "clr");
    wr(BASE + 32'h8, 32'd2, "tld3");
    wr(BASE + 32'hC, 32'h1, "arm");
    rd(BASE + 32'h10, "c1");
    rd(BASE + 32'h10, "c2");
    wr(BASE + 32'hC, 32'h4, "w1cx");
    rd(BASE + 32'hC, "xsts");

    // Reset mid-count.
    wr(BASE + 32'h8, 32'd9, "tld9");
    wr(BASE + 32'hC, 32'h1, "run");
    for (int i = 0; i < 4; i++) rd(BASE + 32'h10, "cnt");
    step(1'b1, BASE + 32'hC, 32'h3, 1'b1, 1'b1, "rstm");
    rd(BASE + 32'h10, "pcnt");
    rd(BASE + 32'hC, "pctl");
    wr(BASE + 32'hC, 32'h3, "ctlw");
    rd(BASE + 32'hC, "ctlr");

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 9);
      if (r <= 5)      a = BASE + ($urandom_range(0, 7) << 2) + $urandom_range(0, 3);
      else if (r == 6) a = BASE + ($urandom_range(1, 7) << 5) + $urandom_range(0, 31);
      else             a = $urandom & 32'h7FFF_FFFF;
      we  = ($urandom_range(0, 2) == 0);
      wd  = (a[4:2] == 3'd2) ? 32'($urandom_range(0, 6)) : $urandom;
      rst = ($urandom_range(0, 59) == 0);
      step(rst, a, wd, we, 1'b1, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
